// File: rtl/alu_pipe_pkg.sv
// alu_pipe shared types: op encoding, status bit indices, FSM states.
// Decimal support in alu_pipe is enabled by defining ALU_DECIMAL_EN.
package alu_pipe_pkg;

  typedef enum logic [4:0] {
    OP_ADD_NZ  = 5'd0,
    OP_SUB_NZ  = 5'd1,
    OP_CMP     = 5'd2,
    OP_ADC     = 5'd3,
    OP_SBC     = 5'd4,
    OP_AND     = 5'd5,
    OP_OR      = 5'd6,
    OP_XOR     = 5'd7,
    OP_ASL     = 5'd8,
    OP_LSR     = 5'd9,
    OP_ROL     = 5'd10,
    OP_ROR     = 5'd11,
    OP_SRC2    = 5'd12,
    OP_BIT     = 5'd13,
    OP_CLR_C   = 5'd14,
    OP_SET_C   = 5'd15,
    OP_CLR_V   = 5'd16,
    OP_SET_V   = 5'd17,
    OP_CLR_I   = 5'd18,
    OP_SET_I   = 5'd19,
    OP_SET_BRK = 5'd20,
    OP_CLR_B   = 5'd21
  } alu_op_t;

  localparam int unsigned ST_C = 0;
  localparam int unsigned ST_Z = 1;
  localparam int unsigned ST_I = 2;
  localparam int unsigned ST_D = 3;
  localparam int unsigned ST_B = 4;
  localparam int unsigned ST_U = 5;
  localparam int unsigned ST_V = 6;
  localparam int unsigned ST_N = 7;

  localparam logic [7:0] STATUS_RESET = 8'h24;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ADJ  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_out_fifo.sv
// Synchronous circular FIFO with head-visible read port.
// Push into a full FIFO is taken only when a pop happens the same cycle.
module alu_out_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_valid,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop & head_valid;
  assign do_push    = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (do_pop & ~do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with status register and result FIFO.
// Define ALU_DECIMAL_EN for BCD ADC/SBC through a one-cycle ADJ state.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             status_ld,
  input  logic [7:0]       status_in,
  output logic [7:0]       status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_flags
);

  localparam int M = WIDTH - 1;

  logic [7:0]       st_q;
  logic [WIDTH-1:0] res;
  logic [7:0]       flg;
  logic [WIDTH:0]   sum;
  logic             c_in;
  logic             upd_nz;
  logic             accept;
  logic             idle;
  logic             push;
  logic             pop;
  logic             full;
  logic [WIDTH+7:0] push_data;
  logic [WIDTH+7:0] head;

  assign status = st_q;
  assign c_in   = st_q[ST_C];
  assign pop    = out_valid & out_ready;
  assign in_ready = idle & (~full | pop);
  assign accept = in_valid & in_ready;

`ifdef ALU_DECIMAL_EN
  logic             dec_op;
  logic [WIDTH:0]   bcd;
  alu_state_t       state;
  alu_state_t       state_n;
  logic [WIDTH+7:0] adj_q;

  function automatic logic [WIDTH:0] bcd_calc(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin,
    input logic             sub
  );
    logic [4:0]       s;
    logic             cy;
    logic [WIDTH-1:0] r;
    cy = sub ? ~cin : cin;
    r  = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      if (sub) begin
        s = {1'b0, x[4*i +: 4]} - {1'b0, y[4*i +: 4]} - {4'b0, cy};
        cy = s[4];
        if (cy) s = s - 5'd6;
      end else begin
        s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0, cy};
        cy = (s > 5'd9);
        if (cy) s = s + 5'd6;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {sub ? ~cy : cy, r};
  endfunction

  assign dec_op = st_q[ST_D] & ((in_op == OP_ADC) | (in_op == OP_SBC));
  assign bcd    = bcd_calc(in_a, in_b, c_in, in_op == OP_SBC);
`endif

  always_comb begin
    res    = '1;
    flg    = st_q;
    sum    = '0;
    upd_nz = 1'b1;
    unique case (in_op)
      OP_ADD_NZ: begin
        sum = {1'b0, in_a} + {1'b0, in_b};
        res = sum[M:0];
      end
      OP_SUB_NZ: begin
        sum = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
        res = sum[M:0];
      end
      OP_CMP: begin
        sum = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(1);
        res = sum[M:0];
        flg[ST_C] = sum[WIDTH];
      end
      OP_ADC: begin
        sum = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(c_in);
        res = sum[M:0];
        flg[ST_C] = sum[WIDTH];
        flg[ST_V] = (in_a[M] == in_b[M]) & (sum[M] != in_a[M]);
      end
      OP_SBC: begin
        sum = {1'b0, in_a} + {1'b0, ~in_b} + (WIDTH+1)'(c_in);
        res = sum[M:0];
        flg[ST_C] = sum[WIDTH];
        flg[ST_V] = (in_a[M] != in_b[M]) & (sum[M] != in_a[M]);
      end
      OP_AND: res = in_a & in_b;
      OP_OR:  res = in_a | in_b;
      OP_XOR: res = in_a ^ in_b;
      OP_ASL: begin
        res = {in_a[M-1:0], 1'b0};
        flg[ST_C] = in_a[M];
      end
      OP_LSR: begin
        res = {1'b0, in_a[M:1]};
        flg[ST_C] = in_a[0];
      end
      OP_ROL: begin
        res = {in_a[M-1:0], c_in};
        flg[ST_C] = in_a[M];
      end
      OP_ROR: begin
        res = {c_in, in_a[M:1]};
        flg[ST_C] = in_a[0];
      end
      OP_SRC2: res = in_b;
      OP_BIT: begin
        res = in_a;
        upd_nz = 1'b0;
        flg[ST_Z] = ~|(in_a & in_b);
        flg[ST_N] = in_b[M];
        flg[ST_V] = in_b[M-1];
      end
      OP_CLR_C:   begin res = in_a; upd_nz = 1'b0; flg[ST_C] = 1'b0; end
      OP_SET_C:   begin res = in_a; upd_nz = 1'b0; flg[ST_C] = 1'b1; end
      OP_CLR_V:   begin res = in_a; upd_nz = 1'b0; flg[ST_V] = 1'b0; end
      OP_SET_V:   begin res = in_a; upd_nz = 1'b0; flg[ST_V] = 1'b1; end
      OP_CLR_I:   begin res = in_a; upd_nz = 1'b0; flg[ST_I] = 1'b0; end
      OP_SET_I:   begin res = in_a; upd_nz = 1'b0; flg[ST_I] = 1'b1; end
      OP_SET_BRK: begin res = in_a; upd_nz = 1'b0; flg[ST_B] = 1'b1; end
      OP_CLR_B:   begin res = in_a; upd_nz = 1'b0; flg[ST_B] = 1'b0; end
      default:    upd_nz = 1'b0;
    endcase
    if (upd_nz) begin
      flg[ST_N] = res[M];
      flg[ST_Z] = ~|res;
    end
`ifdef ALU_DECIMAL_EN
    // N/Z/V stay on the binary sum; only digits and carry are decimal
    if (dec_op) begin
      res       = bcd[M:0];
      flg[ST_C] = bcd[WIDTH];
    end
`endif
    flg[ST_U] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)            st_q <= STATUS_RESET;
    else if (status_ld) st_q <= status_in | 8'h20;
    else if (accept)    st_q <= flg;
  end

`ifdef ALU_DECIMAL_EN
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (accept & dec_op) adj_q <= {flg, res};
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept & dec_op) state_n = S_ADJ;
      S_ADJ:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign idle      = (state == S_IDLE);
  assign push      = (accept & ~dec_op) | (state == S_ADJ);
  assign push_data = (state == S_ADJ) ? adj_q : {flg, res};
`else
  assign idle      = 1'b1;
  assign push      = accept;
  assign push_data = {flg, res};
`endif

  alu_out_fifo #(
    .DW    (WIDTH + 8),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head),
    .head_valid (out_valid),
    .full       (full)
  );

  assign out_data  = head[WIDTH-1:0];
  assign out_flags = head[WIDTH+7:WIDTH];

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational CPU ALU.
- Owns the processor status register and executes one ALU op per accepted request.
- Results go out through a small output FIFO with valid/ready handshakes on both sides.
- Sits between the CPU decode/sequencer and the register-file writeback. It supports generic data width, status load/store, and optional BCD arithmetic.

Parameters:
- WIDTH, 8, data path width in bits; must be ≥4; N = bit WIDTH-1, BIT's V source = bit WIDTH-2.
- OUT_DEPTH, 2, result FIFO entries (1..8); 2 allows full throughput under backpressure.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  5  alu_op_t operation
- in_a  in  WIDTH  operand 1 (accumulator/register side)
- in_b  in  WIDTH  operand 2 (memory/immediate side)
- status_ld  in  1  load status from status_in this cycle (PLP/RTI)
- status_in  in  8  status value to load
- status  out  8  current architectural status (NV1BDIZC)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_data  out  WIDTH  result at FIFO head
- out_flags  out  8  status snapshot after that op

Behaviour:
- Reset: status=8'h24 (bit5=1, I=1); FIFO empty; out_valid=0; FSM=IDLE; in_ready=1 next cycle. Bit 5 always reads 1.
- Op semantics match the existing op set: ADD_NZ, SUB_NZ, CMP, ADC, SBC, AND, OR, XOR, ASL, LSR, ROL, ROR, SRC2, BIT, CLR/SET C/V/I, SET_BRK, CLR_B. All are generalised to WIDTH.
  - Carry = bit WIDTH out of the sum.
  - SBC/CMP carry = NOT borrow.
  - V = signed overflow at the msb.
- Unknown op: result = all ones, status unchanged, entry still pushed.
- Status is updated on the clk edge of acceptance, so op k+1 sees the flags of op k with no bubble.
- Latency: accepted non-decimal op appears at the FIFO head 1 cycle later if the FIFO was empty.
- in_ready = (FSM==IDLE) & (FIFO not full, or a pop this cycle).
- status_ld has priority over a same-cycle accepted op's flag update. The op's result is still pushed with flags computed from the old status.
- FIFO full with out_ready=0: in_ready=0; no data lost or duplicated.
- Pop and push in the same cycle when full: allowed; count unchanged.
- Pointers wrap modulo OUT_DEPTH.
- rst mid-operation: FIFO flushed, in-flight decimal op dropped, status reset.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- With the macro defined:
  - ADC/SBC with status D=1 use BCD, nibble-wise, on WIDTH/4 digits. WIDTH must be a multiple of 4.
  - FSM goes IDLE→ADJ for one cycle, with in_ready=0 during ADJ. The result is pushed at the end of ADJ, for a latency of 2.
  - C = decimal carry/NOT borrow; Z/N/V from the binary intermediate (NMOS 6502 rule).
- Without the macro: D is stored and reported but ignored; NES 2A03 behaviour; FSM stays IDLE.

Decomposition:
- Shared package (enums): alu_op_t, status bit indices N,V,B,D,I,Z,C, STATUS_RESET=8'h24.
- Sub-module alu_out_fifo: parametrised synchronous FIFO (WIDTH+8 bits, OUT_DEPTH entries), reusable elsewhere.
- Op compute stays combinational in alu_pipe.

Test Plan:
1. Reset, then ADC a=8'h50 b=8'h50 C=0 → out 8'hA0; status N=1 V=1 Z=0 C=0; out_valid 1 cycle after accept.
2. Back-to-back SET_C then ADC a=8'hFF b=8'h00 with no bubble → out 8'h00, C=1, Z=1; proves same-cycle flag forwarding.
3. Hold out_ready=0, issue 3 ops with OUT_DEPTH=2 → in_ready drops after 2 accepts. Release → results pop in order; third accepted the cycle a pop frees space.
4. status_ld=1 with status_in=8'h00 together with accepted SET_C → status reads 8'h20. The pushed entry's flags have C=1.
5. With ALU_DECIMAL_EN: SET D, ADC a=8'h19 b=8'h28 C=0 → out 8'h47, C=0, in_ready low for 1 cycle. Without the macro → out 8'h41.
6. WIDTH=16: SBC a=16'h0000 b=16'h0001 C=1 → out 16'hFFFF, C=0, N=1, V=0. Assert rst during a pending result → FIFO empty and status=8'h24 next cycle.
